// File: rtl/cs_address_sequencer_pkg.sv
// Shared constants for the control-store address sequencer.
// Condition codes, FSM encoding, widths and the decode-address helper.
package cs_address_sequencer_pkg;

    localparam int CS_ADDR_W = 11;
    localparam int COND_W    = 3;
    localparam int IR_W      = 32;
    localparam int FLAG_W    = 4;

    localparam logic [COND_W-1:0] COND_NEXT   = 3'b000;
    localparam logic [COND_W-1:0] COND_N      = 3'b001;
    localparam logic [COND_W-1:0] COND_Z      = 3'b010;
    localparam logic [COND_W-1:0] COND_V      = 3'b011;
    localparam logic [COND_W-1:0] COND_C      = 3'b100;
    localparam logic [COND_W-1:0] COND_IR13   = 3'b101;
    localparam logic [COND_W-1:0] COND_JUMP   = 3'b110;
    localparam logic [COND_W-1:0] COND_DECODE = 3'b111;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        STALL      = 2'd2
    } seq_state_t;

    // Opcode fields select a 4-word slot in the upper half of the store.
    function automatic logic [CS_ADDR_W-1:0] decode_addr(
        input logic [IR_W-1:0] ir
    );
        return {1'b1, ir[31:30], ir[24:19], 2'b00};
    endfunction

endpackage

// File: rtl/cs_address_sequencer_psr_flag_register.sv
// Latched copy of the ALU {N,Z,V,C} flags used for branch decisions.
// Loads only when the sequencer grants a load in a non-stalled RUN cycle.
module psr_flag_register
    import cs_address_sequencer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [FLAG_W-1:0] i_flags,
    output logic [FLAG_W-1:0] o_psr
);

    logic [FLAG_W-1:0] r_psr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_psr <= '0;
        end else if (i_load) begin
            r_psr <= i_flags;
        end
    end

    assign o_psr = r_psr;

endmodule

// File: rtl/cs_address_sequencer.sv
// Microprogram next-address sequencer with condition branching and stall.
// Optional watchdog enabled by defining CS_SEQUENCER_WATCHDOG_EN.
module cs_address_sequencer
    import cs_address_sequencer_pkg::*;
#(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_IR          = 32,
    parameter int WATCHDOG_LIMIT        = 255
) (
    input  logic                             CS_SEQUENCER_CLOCK_50,
    input  logic                             CS_SEQUENCER_ResetInHigh_In,
    input  logic [DATAWIDTH_CONDITION-1:0]   CS_SEQUENCER_Condition_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_SEQUENCER_JumpAddress_InBus,
    input  logic [DATAWIDTH_IR-1:0]          CS_SEQUENCER_IR_InBus,
    input  logic [FLAG_W-1:0]                CS_SEQUENCER_Flags_InBus,
    input  logic                             CS_SEQUENCER_FlagLoad_In,
    input  logic                             CS_SEQUENCER_Stall_In,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] CS_SEQUENCER_CSAddress_OutBus,
    output logic [FLAG_W-1:0]                CS_SEQUENCER_PSR_OutBus,
    output logic                             CS_SEQUENCER_Timeout_Out
);

    localparam int AW = DATAWIDTH_JUMPADDRESS;

    seq_state_t        r_state;
    logic [AW-1:0]     r_cs;
    logic [AW-1:0]     r_mir;
    logic              r_timeout;

    logic [FLAG_W-1:0] w_psr;
    logic              w_take;
    logic [AW-1:0]     w_inc;
    logic [AW-1:0]     w_decode;
    logic [AW-1:0]     w_next;
    logic              w_advance;
    logic              w_flag_load;
    logic              w_wd_hit;
    logic              w_unused_ir;

    assign w_advance   = !CS_SEQUENCER_Stall_In
                         && (r_state == RUN || r_state == STALL);
    assign w_flag_load = CS_SEQUENCER_FlagLoad_In
                         && !CS_SEQUENCER_Stall_In
                         && (r_state == RUN);

    psr_flag_register u_psr (
        .i_clk   (CS_SEQUENCER_CLOCK_50),
        .i_rst   (CS_SEQUENCER_ResetInHigh_In),
        .i_load  (w_flag_load),
        .i_flags (CS_SEQUENCER_Flags_InBus),
        .o_psr   (w_psr)
    );

    assign w_inc       = r_mir + 1'b1;
    assign w_decode    = AW'(decode_addr(IR_W'(CS_SEQUENCER_IR_InBus)));
    assign w_unused_ir = ^CS_SEQUENCER_IR_InBus;

    always_comb begin
        w_take = 1'b0;
        unique case (COND_W'(CS_SEQUENCER_Condition_InBus))
            COND_NEXT:   w_take = 1'b0;
            COND_N:      w_take = w_psr[3];
            COND_Z:      w_take = w_psr[2];
            COND_V:      w_take = w_psr[1];
            COND_C:      w_take = w_psr[0];
            COND_IR13:   w_take = CS_SEQUENCER_IR_InBus[13];
            COND_JUMP:   w_take = 1'b1;
            COND_DECODE: w_take = 1'b0;
            default:     w_take = 1'b0;
        endcase
    end

    always_comb begin
        w_next = w_inc;
        if (COND_W'(CS_SEQUENCER_Condition_InBus) == COND_DECODE) begin
            w_next = w_decode;
        end else if (w_take) begin
            w_next = CS_SEQUENCER_JumpAddress_InBus;
        end
    end

`ifdef CS_SEQUENCER_WATCHDOG_EN
    localparam int WD_W = (WATCHDOG_LIMIT < 256) ? 8
                        : $clog2(WATCHDOG_LIMIT + 1);

    logic [WD_W-1:0] r_wd_cnt;

    // Fires on the LIMIT-th consecutive non-zero RUN cycle.
    assign w_wd_hit = (r_cs != '0)
                      && (r_wd_cnt == WD_W'(WATCHDOG_LIMIT - 1));

    always_ff @(posedge CS_SEQUENCER_CLOCK_50) begin
        if (CS_SEQUENCER_ResetInHigh_In) begin
            r_wd_cnt <= '0;
        end else if (r_cs == '0) begin
            r_wd_cnt <= '0;
        end else if (w_advance) begin
            r_wd_cnt <= w_wd_hit ? '0 : r_wd_cnt + 1'b1;
        end
    end
`else
    logic [31:0] w_unused_wd;

    assign w_unused_wd = 32'(WATCHDOG_LIMIT);
    assign w_wd_hit    = 1'b0;
`endif

    always_ff @(posedge CS_SEQUENCER_CLOCK_50) begin
        if (CS_SEQUENCER_ResetInHigh_In) begin
            r_state   <= RESET_HOLD;
            r_cs      <= '0;
            r_mir     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                RESET_HOLD: begin
                    r_state <= RUN;
                    r_cs    <= '0;
                    r_mir   <= '0;
                end
                RUN, STALL: begin
                    if (CS_SEQUENCER_Stall_In) begin
                        r_state <= STALL;
                    end else begin
                        r_state   <= RUN;
                        r_mir     <= r_cs;
                        r_cs      <= w_wd_hit ? '0 : w_next;
                        r_timeout <= w_wd_hit;
                    end
                end
                default: r_state <= RESET_HOLD;
            endcase
        end
    end

    assign CS_SEQUENCER_CSAddress_OutBus = r_cs;
    assign CS_SEQUENCER_PSR_OutBus       = w_psr;
    assign CS_SEQUENCER_Timeout_Out      = r_timeout;

endmodule
